// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - shared codes, state enums and default latencies for the issue scheduler
package exu_pkg;

  localparam logic [1:0] EXU_ALU = 2'b00;
  localparam logic [1:0] EXU_MDU = 2'b01;
  localparam logic [1:0] EXU_FPU = 2'b10;

  localparam int DEF_MDU_LAT = 4;
  localparam int DEF_FPU_LAT = 6;
  localparam int DEF_CNT_W   = 4;

  typedef enum logic [1:0] {IDLE, BUSY, WB_PEND} unit_state_e;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} glb_state_e;

endpackage

// File: rtl/exu_unit_tracker.sv
// rtl/exu_unit_tracker.sv - latency counter, busy/writeback FSM and latched destination of one unit
module exu_unit_tracker
  import exu_pkg::*;
#(
  parameter int LAT   = DEF_MDU_LAT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       en_write,
  input  logic [4:0] dest,
  input  logic       grant,
  output logic       idle,
  output logic       wb_req,
  output logic       wb_pend,
  output logic [4:0] wb_addr
);

  unit_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       dest_q, dest_d;
  logic             en_q, en_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    en_d    = en_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LAT - 1);
          dest_d  = dest;
          en_d    = en_write;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!en_q || grant) begin
          state_d = IDLE;
        end else begin
          state_d = WB_PEND;
        end
      end
      WB_PEND: begin
        if (grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A unit without a destination finishes silently; otherwise it requests until granted.
  always_comb begin
    idle    = (state_q == IDLE);
    wb_pend = (state_q == WB_PEND);
    wb_req  = wb_pend | ((state_q == BUSY) && (cnt_q == '0) && en_q);
    wb_addr = dest_q;
  end

endmodule

// File: rtl/exu_issue_scheduler.sv
// rtl/exu_issue_scheduler.sv - issue gate, register scoreboard, writeback arbiter and halt sequencing
// EXU_ISSUE_BYPASS_EN: hazard check ignores pending bits cleared by this cycle's writeback.
module exu_issue_scheduler
  import exu_pkg::*;
#(
  parameter int MDU_LAT = DEF_MDU_LAT,
  parameter int FPU_LAT = DEF_FPU_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  input  logic [1:0]  iExuOp,
  input  logic [4:0]  iAddrRead0,
  input  logic        iEnRead0,
  input  logic [4:0]  iAddrRead1,
  input  logic        iEnRead1,
  input  logic [4:0]  iAddrWrite,
  input  logic        iEnWrite,
  input  logic        iHalt,
  output logic        oIssue,
  output logic        oStall,
  output logic        oMduStart,
  output logic        oFpuStart,
  output logic        oWbValid,
  output logic        oWbSel,
  output logic [4:0]  oWbAddr,
  output logic [31:0] oPending,
  output logic        oHalted
);

  glb_state_e  glb_q, glb_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] clr_mask, set_mask, hz_pending;
  logic        mdu_idle, mdu_req, mdu_pend, fpu_idle, fpu_req, fpu_pend;
  logic [4:0]  mdu_addr, fpu_addr;
  logic        grant_mdu, grant_fpu, raw, waw, is_mdu, is_fpu, unit_free, issue;
  logic        mdu_start, fpu_start;

  exu_unit_tracker #(.LAT(MDU_LAT), .CNT_W(CNT_W)) u_mdu (
    .clk(iClk), .rst(iRst), .start(mdu_start), .en_write(iEnWrite), .dest(iAddrWrite),
    .grant(grant_mdu), .idle(mdu_idle), .wb_req(mdu_req), .wb_pend(mdu_pend), .wb_addr(mdu_addr)
  );

  exu_unit_tracker #(.LAT(FPU_LAT), .CNT_W(CNT_W)) u_fpu (
    .clk(iClk), .rst(iRst), .start(fpu_start), .en_write(iEnWrite), .dest(iAddrWrite),
    .grant(grant_fpu), .idle(fpu_idle), .wb_req(fpu_req), .wb_pend(fpu_pend), .wb_addr(fpu_addr)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pending_q <= '0;
      glb_q     <= RUN;
    end else begin
      pending_q <= pending_d;
      glb_q     <= glb_d;
    end
  end

  // A waiting requester outranks a fresh one; ties go to the MDU.
  always_comb begin
    grant_mdu = ~iRst & mdu_req & (mdu_pend | ~fpu_pend);
    grant_fpu = ~iRst & fpu_req & ~grant_mdu;
    clr_mask  = '0;
    if (grant_mdu) clr_mask[mdu_addr] = 1'b1;
    if (grant_fpu) clr_mask[fpu_addr] = 1'b1;
`ifdef EXU_ISSUE_BYPASS_EN
    hz_pending = pending_q & ~clr_mask;
`else
    hz_pending = pending_q;
`endif
    raw       = (iEnRead0 & hz_pending[iAddrRead0]) | (iEnRead1 & hz_pending[iAddrRead1]);
    waw       = iEnWrite & hz_pending[iAddrWrite];
    is_mdu    = ~iHalt & (iExuOp == EXU_MDU);
    is_fpu    = ~iHalt & (iExuOp == EXU_FPU);
    unit_free = is_mdu ? mdu_idle : (is_fpu ? fpu_idle : 1'b1);
    issue     = iValid & ~iRst & (glb_q == RUN) & ~raw & ~waw & unit_free;
    mdu_start = issue & is_mdu;
    fpu_start = issue & is_fpu;
    set_mask  = '0;
    if ((mdu_start | fpu_start) & iEnWrite) set_mask[iAddrWrite] = 1'b1;
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    glb_d = glb_q;
    case (glb_q)
      RUN:     if (issue && iHalt) glb_d = DRAIN;
      DRAIN:   if (mdu_idle && fpu_idle) glb_d = HALTED;
      HALTED:  glb_d = HALTED;
      default: glb_d = RUN;
    endcase
  end

  always_comb begin
    oIssue    = issue;
    oStall    = iValid & ~issue;
    oMduStart = mdu_start;
    oFpuStart = fpu_start;
    oWbValid  = grant_mdu | grant_fpu;
    oWbSel    = grant_fpu;
    oWbAddr   = grant_fpu ? fpu_addr : (grant_mdu ? mdu_addr : 5'd0);
    oPending  = pending_q;
    oHalted   = (glb_q == HALTED);
  end

endmodule

// File: tb/tb_exu_issue_scheduler.sv
// tb/tb_exu_issue_scheduler.sv - scoreboard bench for exu_issue_scheduler (MDU_LAT=4, FPU_LAT=2)
module tb_exu_issue_scheduler;

  typedef struct {
    logic       sel;
    logic [4:0] addr;
    int         cyc;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        iRst, iValid, iEnRead0, iEnRead1, iEnWrite, iHalt;
  logic [1:0]  iExuOp;
  logic [4:0]  iAddrRead0, iAddrRead1, iAddrWrite;
  logic        oIssue, oStall, oMduStart, oFpuStart, oWbValid, oWbSel, oHalted;
  logic [4:0]  oWbAddr;
  logic [31:0] oPending;

  int      n_checks = 0;
  int      n_pass   = 0;
  int      cyc      = 0;
  wb_exp_t sb[$];

  exu_issue_scheduler #(.MDU_LAT(4), .FPU_LAT(2), .CNT_W(4)) dut (
    .iClk(clk), .iRst(iRst), .iValid(iValid), .iExuOp(iExuOp),
    .iAddrRead0(iAddrRead0), .iEnRead0(iEnRead0), .iAddrRead1(iAddrRead1), .iEnRead1(iEnRead1),
    .iAddrWrite(iAddrWrite), .iEnWrite(iEnWrite), .iHalt(iHalt),
    .oIssue(oIssue), .oStall(oStall), .oMduStart(oMduStart), .oFpuStart(oFpuStart),
    .oWbValid(oWbValid), .oWbSel(oWbSel), .oWbAddr(oWbAddr), .oPending(oPending), .oHalted(oHalted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] op, input logic [4:0] r0, input logic e0,
                     input logic [4:0] r1, input logic e1, input logic [4:0] w, input logic ew,
                     input logic h);
    iValid = v; iExuOp = op; iAddrRead0 = r0; iEnRead0 = e0; iAddrRead1 = r1; iEnRead1 = e1;
    iAddrWrite = w; iEnWrite = ew; iHalt = h;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic push(input logic sel, input logic [4:0] addr, input int c);
    wb_exp_t e;
    e.sel = sel; e.addr = addr; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_issue(input int max, output int at, output int stalls);
    at = -1;
    stalls = 0;
    for (int i = 0; i < max; i++) begin
      #1;
      if (oIssue) begin
        at = cyc;
        break;
      end
      if (oStall) stalls++;
      tick();
    end
    if (at < 0) check("issue_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (oWbValid) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 1, 0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        check("wb_sel", oWbSel, e.sel);
        check("wb_addr", oWbAddr, e.addr);
        check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c0, at, st, exp_at, exp_st;
    iRst = 1'b1;
    drv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    iRst = 1'b0;
    #1;
    check("rst_pending", oPending, 0);
    check("rst_halted", oHalted, 0);
    check("rst_wb", oWbValid, 0);
    check("rst_issue", oIssue, 0);

    // MDU r5 then dependent ADD
    tick(); drv(1, 2'b01, 0, 0, 0, 0, 5, 1, 0); c0 = cyc;
    #1;
    check("t1_issue", oIssue, 1);
    check("t1_mdu_start", oMduStart, 1);
    push(0, 5, c0 + 4);
    tick(); drv(1, 2'b00, 5, 1, 0, 0, 8, 1, 0);
    #1;
    check("t1_pending", oPending, 32'h20);
`ifdef EXU_ISSUE_BYPASS_EN
    exp_at = c0 + 4; exp_st = 3;
`else
    exp_at = c0 + 5; exp_st = 4;
`endif
    wait_issue(20, at, st);
    check("t1_add_issue_cyc", at, exp_at);
    check("t1_stall_cycles", st, exp_st);
    idle(1);
    #1;
    check("t1_pending_clr", oPending, 0);
    idle(4);

    // MDU r3 and FPU r4 collide on writeback
    tick(); drv(1, 2'b01, 0, 0, 0, 0, 3, 1, 0); c0 = cyc;
    push(0, 3, c0 + 4);
    idle(1);
    tick(); drv(1, 2'b10, 0, 0, 0, 0, 4, 1, 0);
    #1;
    check("t2_fpu_start", oFpuStart, 1);
    push(1, 4, c0 + 5);
    idle(1);
    #1;
    check("t2_pending", oPending, 32'h18);
    idle(6);
    check("t2_pending_clr", oPending, 0);

    // back-to-back MDU
    tick(); drv(1, 2'b01, 0, 0, 0, 0, 6, 1, 0); c0 = cyc;
    push(0, 6, c0 + 4);
    tick(); drv(1, 2'b01, 0, 0, 0, 0, 7, 1, 0);
    wait_issue(20, at, st);
    check("t3_issue_cyc", at, c0 + 5);
    check("t3_pending_gap", oPending, 0);
    push(0, 7, at + 4);
    idle(1);
    #1;
    check("t3_pending_r7", oPending, 32'h80);
    idle(6);

    // r0 never pending
    tick(); drv(1, 2'b01, 0, 0, 0, 0, 0, 1, 0); c0 = cyc;
    #1;
    check("t4_issue", oIssue, 1);
    push(0, 0, c0 + 4);
    tick(); drv(1, 2'b00, 0, 1, 0, 1, 9, 1, 0);
    #1;
    check("t4_pending", oPending, 0);
    check("t4_read_issue", oIssue, 1);
    check("t4_no_stall", oStall, 0);
    idle(6);

    // HALT with FPU in flight
    tick(); drv(1, 2'b10, 0, 0, 0, 0, 9, 1, 0); c0 = cyc;
    #1;
    check("t5_fpu_issue", oIssue, 1);
    push(1, 9, c0 + 2);
    tick(); drv(1, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("t5_halt_issue", oIssue, 1);
    tick(); drv(1, 2'b00, 2, 1, 0, 0, 12, 1, 0);
    #1;
    check("t5_add_stall", oStall, 1);
    tick();
    check("t5_not_halted", oHalted, 0);
    check("t5_drain_stall", oStall, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_halted", oHalted, 1);
      check("t5_halted_stall", oStall, 1);
    end
    drv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    #1;
    check("t5_halt_cleared", oHalted, 0);

    // reset while MDU busy
    tick(); drv(1, 2'b01, 0, 0, 0, 0, 10, 1, 0);
    #1;
    check("t6_issue", oIssue, 1);
    idle(1);
    tick(); drv(1, 2'b01, 0, 0, 0, 0, 13, 1, 0);
    iRst = 1'b1;
    #1;
    check("t6_rst_no_start", oMduStart, 0);
    check("t6_rst_no_wb", oWbValid, 0);
    tick(); iRst = 1'b0;
    drv(1, 2'b01, 0, 0, 0, 0, 11, 1, 0);
    #1;
    check("t6_pending_clr", oPending, 0);
    check("t6_reissue", oIssue, 1);
    push(0, 11, cyc + 4);
    idle(8);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
